// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with 50% duty outputs and rise ticks.
// New divisors are applied only at a falling boundary, or right away on a stopped channel.
module clk_div_prog_ch #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 25
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pdv_q, pdv_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             run;
  logic             last;
  logic [CNT_W-1:0] new_div;

  assign run     = (act_q != '0);
  assign last    = (cnt_q == act_q - CNT_W'(1));
  assign new_div = wr_hit ? wr_div : pdv_q;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pdv_d  = pdv_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    pend_d = pend_q;
    if (!run) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        act_d  = new_div;
        pdv_d  = new_div;
        pend_d = 1'b0;
      end else if (wr_hit) begin
        pdv_d  = wr_div;
        pend_d = 1'b1;
      end
    end else if (last) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
      // falling boundary: a same-edge write bypasses the pending slot
      if (clk_q) begin
        act_d  = new_div;
        pdv_d  = new_div;
        pend_d = 1'b0;
      end else if (wr_hit) begin
        pdv_d  = wr_div;
        pend_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (wr_hit) begin
        pdv_d  = wr_div;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q  <= '0;
      act_q  <= CNT_W'(DEFAULT_DIV);
      pdv_q  <= CNT_W'(DEFAULT_DIV);
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pdv_q  <= pdv_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

module clk_div_prog #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 25,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  logic [NUM_CH-1:0] wr_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // channel indices past NUM_CH-1 never match, so those writes drop
    assign wr_hit[i] = wr_en && (wr_ch == CH_W'(i));

    clk_div_prog_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .wr_hit  (wr_hit[i]),
      .wr_div  (wr_div),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: random + directed stimulus against a period-position model.
// Expected outputs are queued per edge and checked by an independent monitor.
module tb_clk_div_prog;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DEF = 25;

  logic           clk_in = 1'b0;
  logic           reset  = 1'b1;
  logic           wr_en  = 1'b0;
  logic [1:0]     wr_ch  = '0;
  logic [CW-1:0]  wr_div = '0;
  logic [NCH-1:0] clk_out, tick, pend;

  clk_div_prog #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [NCH-1:0] c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscomp = 0;
  int   ncyc    = 0;

  // model: n = half period, e = edges since start of the current low phase
  int m_n[NCH];
  int m_p[NCH];
  int m_e[NCH];
  bit m_f[NCH];

  function automatic bit lvl(int c);
    return m_n[c] != 0 && ((m_e[c] / m_n[c]) % 2 == 1);
  endfunction

  task automatic cyc(bit r, bit en, int ch, int div);
    exp_t x;
    bit   hit;
    @(negedge clk_in);
    reset  = r;
    wr_en  = en;
    wr_ch  = 2'(ch);
    wr_div = CW'(div);
    ncyc++;
    x = '0;
    for (int c = 0; c < NCH; c++) begin
      hit = en && (ch == c);
      if (r) begin
        m_n[c] = DEF; m_p[c] = DEF; m_f[c] = 0; m_e[c] = 0;
      end else if (m_n[c] == 0) begin
        m_e[c] = 0;
        if (m_f[c]) begin
          m_n[c] = hit ? div : m_p[c];
          m_p[c] = m_n[c];
          m_f[c] = 0;
        end else if (hit) begin
          m_p[c] = div; m_f[c] = 1;
        end
      end else begin
        m_e[c]++;
        if (m_e[c] == 2 * m_n[c]) begin
          m_e[c] = 0;
          m_n[c] = hit ? div : (m_f[c] ? m_p[c] : m_n[c]);
          m_p[c] = m_n[c];
          m_f[c] = 0;
        end else if (hit) begin
          m_p[c] = div; m_f[c] = 1;
        end
        x.t[c] = (m_n[c] != 0) && (m_e[c] == m_n[c]);
      end
      x.c[c] = lvl(c);
      x.p[c] = m_f[c];
    end
    q.push_back(x);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
  endtask

  task automatic wr(int ch, int div);
    cyc(0, 1, ch, div);
  endtask

  task automatic timeout(string what);
    vectors++;
    miscomp++;
    $display("FAIL wait %s: condition not reached, required within bound", what);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if ({clk_out, tick, pend} !== e) begin
          miscomp++;
          $display("FAIL edge %0d: clk_out=%b want %b tick=%b want %b pend=%b want %b",
                   ncyc, clk_out, e.c, tick, e.t, pend, e.p);
        end
      end
    end
  end

  initial begin : driver
    int k;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 7);
    idle(200);

    wr(0, 4);
    idle(60);
    for (k = 0; k < 100 && m_e[0] != 5; k++) idle(1);
    if (m_e[0] != 5) timeout("ch0 high phase");
    wr(0, 2);
    idle(30);

    wr(1, 3);
    idle(60);
    wr(1, 0);
    idle(20);
    wr(1, 3);
    idle(20);

    wr(2, 5);
    idle(60);
    for (k = 0; k < 100 && !(m_n[2] == 5 && m_e[2] == 9); k++) idle(1);
    if (!(m_n[2] == 5 && m_e[2] == 9)) timeout("ch2 boundary");
    wr(2, 7);
    idle(30);
    wr(3, 9);
    idle(10);

    for (k = 0; k < 100 && !(lvl(0) && m_e[0] < 2 * m_n[0] - 2); k++) idle(1);
    if (!lvl(0)) timeout("ch0 high");
    wr(0, 6);
    cyc(1, 1, 0, 3);
    idle(60);

    wr(0, 255);
    idle(1100);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) cyc(1, $urandom_range(1), $urandom_range(3), 3);
      else if ($urandom_range(7) == 0)
        wr($urandom_range(3), ($urandom_range(31) == 0) ? 255 : $urandom_range(6));
      else idle(1);
    end

    idle(2);
    @(posedge clk_in);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscomp++;
      $display("FAIL drain: %0d left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

endmodule
